// File: rtl/guess_solver_if.sv
// guess_solver_if: handshake bundle between a code scorer and guess_solver.
//   start       : one-cycle pulse, begins a new game
//   fb_valid    : one-cycle pulse, feedback for the current guess is present
//   fb_black    : right digit, right position (0..4)
//   fb_white    : right digit, wrong position (0..4)
//   guess       : current guess, d0=[11:9] d1=[8:6] d2=[5:3] d3=[2:0], digits 0..6
//   guess_valid : guess is stable and awaiting feedback
//   busy        : search in progress
//   solved      : last feedback was black=4
//   fail        : limit reached, no consistent candidate, or illegal feedback
//   guess_count : feedbacks accepted in this game
// master = scorer side, slave = solver side.
interface guess_solver_if;
    logic        start;
    logic        fb_valid;
    logic [2:0]  fb_black;
    logic [2:0]  fb_white;
    logic [11:0] guess;
    logic        guess_valid;
    logic        busy;
    logic        solved;
    logic        fail;
    logic [3:0]  guess_count;

    modport master (
        output start, fb_valid, fb_black, fb_white,
        input  guess, guess_valid, busy, solved, fail, guess_count
    );

    modport slave (
        input  start, fb_valid, fb_black, fb_white,
        output guess, guess_valid, busy, solved, fail, guess_count
    );
endinterface

// File: rtl/guess_solver.sv
// guess_solver: Mastermind-style code breaker over 4 digits in 0..6.
// Guesses the lowest base-7 code (d0 most significant) above the previous
// guess that is consistent with every recorded feedback, testing one
// (candidate, history entry) pair per clock.
// Ports:
//   MAX10_CLK1_50 : clock, rising edge
//   reset         : synchronous, active-high
//   bus           : guess_solver_if.slave (start/feedback in, guess/status out)
// Parameter:
//   MAX_GUESSES   : feedbacks allowed before giving up (1..15), also history depth
module guess_solver #(
    parameter int unsigned MAX_GUESSES = 10
) (
    input  logic          MAX10_CLK1_50,
    input  logic          reset,
    guess_solver_if.slave bus
);
    localparam int unsigned IDX_W     = (MAX_GUESSES > 1) ? $clog2(MAX_GUESSES) : 1;
    localparam logic [11:0] LAST_CODE = 12'o6666;

    typedef enum logic [2:0] {StIdle, StEmit, StStore, StSearch, StSolved, StFail} state_t;

    state_t      r_state;
    logic [11:0] r_guess;
    logic [3:0]  r_count;
    logic [2:0]  r_fb_black;
    logic [2:0]  r_fb_white;
    logic [11:0] r_cand;
    logic [3:0]  r_idx;

    logic [11:0] r_hist_guess [MAX_GUESSES];
    logic [2:0]  r_hist_black [MAX_GUESSES];
    logic [2:0]  r_hist_white [MAX_GUESSES];

    // Black/white score of two codes, packed as {black, white}.
    function automatic logic [5:0] score7(input logic [11:0] a, input logic [11:0] b);
        logic [2:0] blk;
        logic [2:0] tot;
        logic [2:0] na;
        logic [2:0] nb;
        blk = '0;
        tot = '0;
        for (int i = 0; i < 4; i++) begin
            if (a[i*3 +: 3] == b[i*3 +: 3]) blk = blk + 3'd1;
        end
        for (int v = 0; v < 7; v++) begin
            na = '0;
            nb = '0;
            for (int i = 0; i < 4; i++) begin
                if (a[i*3 +: 3] == 3'(v)) na = na + 3'd1;
                if (b[i*3 +: 3] == 3'(v)) nb = nb + 3'd1;
            end
            tot = tot + ((na < nb) ? na : nb);
        end
        return {blk, tot - blk};
    endfunction

    // Base-7 increment, d3 ([2:0]) least significant. Caller guards 6666.
    function automatic logic [11:0] inc7(input logic [11:0] c);
        logic [11:0] r;
        logic        carry;
        r     = c;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*3 +: 3] == 3'd6) begin
                    r[i*3 +: 3] = 3'd0;
                end else begin
                    r[i*3 +: 3] = r[i*3 +: 3] + 3'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic [3:0]       w_count_inc;
    logic [3:0]       w_count_m1;
    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_wr_idx;
    logic [5:0]       w_score;
    logic             w_match;
    logic             w_last_entry;
    logic [3:0]       w_fb_sum;

    assign w_count_inc  = r_count + 4'd1;
    assign w_count_m1   = r_count - 4'd1;
    assign w_rd_idx     = r_idx[IDX_W-1:0];
    assign w_wr_idx     = w_count_m1[IDX_W-1:0];
    assign w_score      = score7(r_cand, r_hist_guess[w_rd_idx]);
    assign w_match      = (w_score == {r_hist_black[w_rd_idx], r_hist_white[w_rd_idx]});
    assign w_last_entry = (r_idx == w_count_m1);
    assign w_fb_sum     = {1'b0, bus.fb_black} + {1'b0, bus.fb_white};

    // History is only ever read below r_count, so it carries no reset.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (r_state == StStore) begin
            r_hist_guess[w_wr_idx] <= r_guess;
            r_hist_black[w_wr_idx] <= r_fb_black;
            r_hist_white[w_wr_idx] <= r_fb_white;
        end
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            r_state    <= StIdle;
            r_guess    <= '0;
            r_count    <= '0;
            r_fb_black <= '0;
            r_fb_white <= '0;
            r_cand     <= '0;
            r_idx      <= '0;
        end else if (bus.start) begin
            // start wins over fb_valid and aborts any state, even mid-search
            r_state <= StEmit;
            r_guess <= '0;
            r_count <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                StEmit: begin
                    if (bus.fb_valid) begin
                        r_count    <= w_count_inc;
                        r_fb_black <= bus.fb_black;
                        r_fb_white <= bus.fb_white;
                        if (bus.fb_black == 3'd4) begin
                            r_state <= StSolved;
                        end else if (w_fb_sum > 4'd4) begin
                            r_state <= StFail;
                        end else if (w_count_inc == 4'(MAX_GUESSES)) begin
                            r_state <= StFail;
                        end else begin
                            r_state <= StStore;
                        end
                    end
                end
                StStore: begin
                    r_idx <= '0;
                    if (r_guess == LAST_CODE) begin
                        r_state <= StFail;
                    end else begin
                        r_cand  <= inc7(r_guess);
                        r_state <= StSearch;
                    end
                end
                StSearch: begin
                    if (w_match) begin
                        if (w_last_entry) begin
                            r_guess <= r_cand;
                            r_state <= StEmit;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end else if (r_cand == LAST_CODE) begin
                        r_state <= StFail;
                    end else begin
                        r_cand <= inc7(r_cand);
                        r_idx  <= '0;
                    end
                end
                default: ; // idle, solved and fail hold until start
            endcase
        end
    end

    assign bus.guess       = r_guess;
    assign bus.guess_valid = (r_state == StEmit);
    assign bus.busy        = (r_state == StStore) || (r_state == StSearch);
    assign bus.solved      = (r_state == StSolved);
    assign bus.fail        = (r_state == StFail);
    assign bus.guess_count = r_count;
endmodule

// File: tb/tb_guess_solver.sv
// Directed bench for guess_solver. Stimulus pushes the expected next event
// (guess emitted / solved / fail) into a per-DUT queue; a negedge monitor pops
// and compares on each rising guess_valid, solved or fail.
// DUT A uses MAX_GUESSES=10, DUT B uses MAX_GUESSES=2.
module tb_guess_solver;
    logic clk;
    logic reset;

    guess_solver_if bus_a ();
    guess_solver_if bus_b ();

    guess_solver #(.MAX_GUESSES(10)) u_a (
        .MAX10_CLK1_50 (clk),
        .reset         (reset),
        .bus           (bus_a)
    );

    guess_solver #(.MAX_GUESSES(2)) u_b (
        .MAX10_CLK1_50 (clk),
        .reset         (reset),
        .bus           (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        gv;
        logic [11:0] guess;
        logic        busy;
        logic        solved;
        logic        fail;
        logic [3:0]  cnt;
    } outs_t;

    typedef struct {
        int          kind; // 0 guess, 1 solved, 2 fail
        logic [11:0] g;
        int          cnt;
    } exp_t;

    exp_t q_a [$];
    exp_t q_b [$];
    logic p_gv  [2] = '{1'b0, 1'b0};
    logic p_sol [2] = '{1'b0, 1'b0};
    logic p_fl  [2] = '{1'b0, 1'b0};

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic outs_t outs(input int id);
        outs_t o;
        if (id == 0) begin
            o = {bus_a.guess_valid, bus_a.guess, bus_a.busy, bus_a.solved, bus_a.fail,
                 bus_a.guess_count};
        end else begin
            o = {bus_b.guess_valid, bus_b.guess, bus_b.busy, bus_b.solved, bus_b.fail,
                 bus_b.guess_count};
        end
        return o;
    endfunction

    task automatic drv(input int id, input logic st, input logic fv,
                       input logic [2:0] b, input logic [2:0] w);
        if (id == 0) begin
            bus_a.start = st; bus_a.fb_valid = fv; bus_a.fb_black = b; bus_a.fb_white = w;
        end else begin
            bus_b.start = st; bus_b.fb_valid = fv; bus_b.fb_black = b; bus_b.fb_white = w;
        end
    endtask

    task automatic push(input int id, input int kind, input logic [11:0] g, input int cnt);
        exp_t e;
        e.kind = kind;
        e.g    = g;
        e.cnt  = cnt;
        if (id == 0) q_a.push_back(e);
        else q_b.push_back(e);
    endtask

    task automatic pulse_start(input int id);
        drv(id, 1'b1, 1'b0, 3'd0, 3'd0);
        @(negedge clk);
        drv(id, 1'b0, 1'b0, 3'd0, 3'd0);
    endtask

    task automatic pulse_fb(input int id, input logic [2:0] b, input logic [2:0] w);
        drv(id, 1'b0, 1'b1, b, w);
        @(negedge clk);
        drv(id, 1'b0, 1'b0, 3'd0, 3'd0);
    endtask

    task automatic wait_gv(input int id);
        outs_t o;
        int    n;
        n = 0;
        o = outs(id);
        while (!o.gv && n < 5000) begin
            @(negedge clk);
            n++;
            o = outs(id);
        end
        if (n >= 5000) check("wait guess_valid timeout", 0, 1);
    endtask

    // Independent scorer: black*8 + white.
    function automatic int tb_score(input logic [11:0] a, input logic [11:0] b);
        int ca [8];
        int cb [8];
        int blk;
        int tot;
        blk = 0;
        tot = 0;
        for (int v = 0; v < 8; v++) begin
            ca[v] = 0;
            cb[v] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (a[i*3 +: 3] == b[i*3 +: 3]) blk++;
            ca[a[i*3 +: 3]]++;
            cb[b[i*3 +: 3]]++;
        end
        for (int v = 0; v < 8; v++) tot += (ca[v] < cb[v]) ? ca[v] : cb[v];
        return blk * 8 + (tot - blk);
    endfunction

    task automatic pop_check(input int id, input int kind, input outs_t o);
        exp_t e;
        if ((id == 0 && q_a.size() == 0) || (id == 1 && q_b.size() == 0)) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected event dut %0d: got kind %0d, want none (t=%0t)",
                     id, kind, $time);
            return;
        end
        e = (id == 0) ? q_a.pop_front() : q_b.pop_front();
        check("event kind", kind, e.kind);
        check("count at event", int'(o.cnt), e.cnt);
        if (kind == 0) check("guess", int'(o.guess), int'(e.g));
        if (kind == 2) check("guess_valid at fail", int'(o.gv), 0);
    endtask

    always @(negedge clk) begin
        for (int id = 0; id < 2; id++) begin
            outs_t o;
            o = outs(id);
            if (o.gv === 1'b1 && !p_gv[id]) pop_check(id, 0, o);
            if (o.solved === 1'b1 && !p_sol[id]) pop_check(id, 1, o);
            if (o.fail === 1'b1 && !p_fl[id]) pop_check(id, 2, o);
            p_gv[id]  = (o.gv === 1'b1);
            p_sol[id] = (o.solved === 1'b1);
            p_fl[id]  = (o.fail === 1'b1);
        end
    end

    initial begin
        outs_t       o;
        logic [11:0] gtab [5];
        logic [11:0] hg   [5];
        int          hf   [5];
        logic [2:0]  dg;
        int          s;

        gtab = '{12'o0000, 12'o1111, 12'o1222, 12'o1233, 12'o1234};

        // Reset for two cycles; start in the second cycle must lose to reset.
        reset = 1'b1;
        drv(0, 1'b0, 1'b0, 3'd0, 3'd0);
        drv(1, 1'b0, 1'b0, 3'd0, 3'd0);
        @(negedge clk);
        drv(0, 1'b1, 1'b1, 3'd4, 3'd0);
        @(negedge clk);
        drv(0, 1'b0, 1'b0, 3'd0, 3'd0);
        o = outs(0);
        check("reset guess_valid", int'(o.gv), 0);
        check("reset guess", int'(o.guess), 0);
        check("reset busy", int'(o.busy), 0);
        check("reset solved", int'(o.solved), 0);
        check("reset fail", int'(o.fail), 0);
        check("reset guess_count", int'(o.cnt), 0);
        reset = 1'b0;
        @(negedge clk);

        // Immediate win.
        push(0, 0, 12'o0000, 0);
        pulse_start(0);
        wait_gv(0);
        push(0, 1, '0, 1);
        pulse_fb(0, 3'd4, 3'd0);
        o = outs(0);
        check("win solved", int'(o.solved), 1);
        check("win guess_valid", int'(o.gv), 0);

        // Digit elimination, then inconsistent feedback exhausting the space.
        push(0, 0, 12'o0000, 0);
        pulse_start(0);
        for (int d = 0; d < 7; d++) begin
            wait_gv(0);
            if (d < 6) begin
                dg = 3'(d + 1);
                push(0, 0, {dg, dg, dg, dg}, d + 1);
            end else begin
                push(0, 2, '0, 7);
            end
            pulse_fb(0, 3'd0, 3'd0);
        end
        repeat (20) @(negedge clk);
        o = outs(0);
        check("exhaust fail", int'(o.fail), 1);
        check("exhaust guess held", int'(o.guess), int'(12'o6666));

        // Illegal feedback 3/2.
        push(0, 0, 12'o0000, 0);
        pulse_start(0);
        wait_gv(0);
        push(0, 2, '0, 1);
        pulse_fb(0, 3'd3, 3'd2);
        o = outs(0);
        check("illegal fb fail next cycle", int'(o.fail), 1);

        // Full game, secret 1234.
        push(0, 0, 12'o0000, 0);
        pulse_start(0);
        for (int i = 0; i < 5; i++) begin
            wait_gv(0);
            o = outs(0);
            for (int j = 0; j < i; j++) begin
                check("guess consistent with history", tb_score(o.guess, hg[j]), hf[j]);
            end
            s     = tb_score(o.guess, 12'o1234);
            hg[i] = o.guess;
            hf[i] = s;
            if (i < 4) push(0, 0, gtab[i+1], i + 1);
            else push(0, 1, '0, 5);
            pulse_fb(0, 3'(s / 8), 3'(s % 8));
        end
        o = outs(0);
        check("game solved", int'(o.solved), 1);

        // Restart mid-search.
        push(0, 0, 12'o0000, 0);
        pulse_start(0);
        wait_gv(0);
        pulse_fb(0, 3'd0, 3'd0);
        repeat (2) @(negedge clk);
        o = outs(0);
        check("busy mid-search", int'(o.busy), 1);
        push(0, 0, 12'o0000, 0);
        pulse_start(0);
        o = outs(0);
        check("restart busy", int'(o.busy), 0);
        check("restart guess", int'(o.guess), 0);
        check("restart guess_count", int'(o.cnt), 0);
        check("restart guess_valid", int'(o.gv), 1);
        push(0, 1, '0, 1);
        pulse_fb(0, 3'd4, 3'd0);

        // start and fb_valid together: start wins.
        push(0, 0, 12'o0000, 0);
        pulse_start(0);
        wait_gv(0);
        push(0, 0, 12'o1111, 1);
        pulse_fb(0, 3'd0, 3'd0);
        wait_gv(0);
        drv(0, 1'b1, 1'b1, 3'd4, 3'd0);
        @(negedge clk);
        drv(0, 1'b0, 1'b0, 3'd0, 3'd0);
        o = outs(0);
        check("start+fb solved", int'(o.solved), 0);
        check("start+fb guess", int'(o.guess), 0);
        check("start+fb guess_count", int'(o.cnt), 0);
        check("start+fb guess_valid", int'(o.gv), 1);
        push(0, 1, '0, 1);
        pulse_fb(0, 3'd4, 3'd0);

        // Guess limit with MAX_GUESSES=2.
        push(1, 0, 12'o0000, 0);
        pulse_start(1);
        wait_gv(1);
        push(1, 0, 12'o1111, 1);
        pulse_fb(1, 3'd0, 3'd0);
        wait_gv(1);
        push(1, 2, '0, 2);
        pulse_fb(1, 3'd0, 3'd0);
        o = outs(1);
        check("limit fail", int'(o.fail), 1);
        check("limit guess_count", int'(o.cnt), 2);

        repeat (5) @(negedge clk);
        check("queue a drained", q_a.size(), 0);
        check("queue b drained", q_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/guess_solver.md
GUESS_SOLVER -- requirements
Module: guess_solver

Interface
REQ-001 SHALL have parameter MAX_GUESSES, default 10, meaning the guess limit before giving up (range 1..15).
REQ-002 SHALL have port MAX10_CLK1_50  in  1  the single clock; every register updates on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port start  in  1  one-cycle pulse that begins a new game.
REQ-005 SHALL have port fb_valid  in  1  one-cycle pulse; scorer feedback for the current guess is present.
REQ-006 SHALL have port fb_black  in  3  count of right digits in the right position (0..4).
REQ-007 SHALL have port fb_white  in  3  count of right digits in the wrong position (0..4).
REQ-008 SHALL have port guess  out  12  current guess; d0=[11:9], d1=[8:6], d2=[5:3], d3=[2:0].
REQ-009 SHALL have port guess_valid  out  1  guess is stable and awaiting feedback.
REQ-010 SHALL have port busy  out  1  a search is in progress.
REQ-011 SHALL have port solved  out  1  the last feedback was black=4.
REQ-012 SHALL have port fail  out  1  limit reached, no consistent candidate exists, or feedback is illegal.
REQ-013 SHALL have port guess_count  out  4  number of feedbacks accepted in this game.

Function
REQ-014 Digits SHALL be restricted to 0..6, because the scorer reserves 7 as its removal sentinel; the candidate space is 7^4 = 2401 codes, counted in base 7 with d0 most significant.
REQ-015 Scoring rule: black = number of positions that match; white = sum over v of min(count of v in guess, count of v in candidate) - black.
REQ-016 State machine states: IDLE, EMIT, STORE, SEARCH, SOLVED, FAIL.
REQ-017 start SHALL take effect from any state, including mid-SEARCH:
- clear history and guess_count;
- load guess=0000;
- enter EMIT, so guess_valid=1 on the next cycle.
REQ-018 In EMIT, guess and guess_valid SHALL hold steady until fb_valid arrives; fb_valid in any other state SHALL be ignored.
REQ-019 On fb_valid in EMIT:
- guess_valid drops next cycle and guess_count increments;
- if fb_black=4, go to SOLVED;
- else if fb_black+fb_white>4, go to FAIL;
- else if the new guess_count equals MAX_GUESSES, go to FAIL;
- otherwise go to STORE.
REQ-020 STORE SHALL write {guess, fb_black, fb_white} into history[guess_count-1]; the history depth is MAX_GUESSES.
REQ-021 SEARCH SHALL start from the candidate (last guess + 1) and evaluate exactly one (candidate, history entry) pair per cycle:
- mismatch: advance to the next candidate and reset the entry index to 0;
- match on the last valid entry: the candidate becomes guess, and the block enters EMIT on the next cycle.
REQ-022 If the candidate would step past 6666 during SEARCH, the block SHALL enter FAIL; the candidate never wraps to 0000.
REQ-023 busy SHALL be 1 exactly in the STORE and SEARCH states.
REQ-024 SOLVED and FAIL SHALL be terminal until start or reset; guess holds its last value in both.
REQ-025 When start and fb_valid arrive in the same cycle, start SHALL win.

Reset
REQ-026 While reset is high, the block SHALL be in IDLE with all outputs 0 (guess=000000000000, guess_count=0).
REQ-027 Reset SHALL take priority over start and fb_valid.
REQ-028 History contents need no reset, because they are never read beyond guess_count.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Reset: reset high for 2 cycles -> all outputs 0, state IDLE.
- Immediate win: start -> next cycle guess_valid=1, guess=0000; fb 4/0 -> solved=1, guess_count=1, guess_valid=0.
- Digit elimination: start, fb 0/0 for 0000 -> next guess 1111; fb 0/0 -> next guess 2222.
- Full game: reference scorer model with secret 1,2,3,4 -> solved within 10 guesses; every emitted guess scores identically to the secret against all prior history.
- Inconsistent feedback: fb 0/0 to 0000 through 5555, then fb 0/0 to 6666 -> fail=1 with no further guess emitted; separately, fb 3/2 -> fail=1 next cycle.
- Restart and limit: start pulsed mid-SEARCH -> busy=0, guess=0000, guess_count=0; with MAX_GUESSES=2, two non-win feedbacks -> fail=1, guess_count=2.
